// File: rtl/lsu_wb_ctrl_if.sv
// Core-request, data-memory and register-file write-port bundle for lsu_wb_ctrl.
// slave = the load/store unit, master = the core/memory environment driving it.
interface lsu_wb_ctrl_if #(parameter int Width = 32);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [Width-1:0] req_addr_i;
  logic [Width-1:0] req_wdata_i;
  logic [4:0]       req_rd_i;

  logic             mem_req_o;
  logic             mem_we_o;
  logic [Width-1:0] mem_addr_o;
  logic [3:0]       mem_be_o;
  logic [Width-1:0] mem_wdata_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i;
  logic [Width-1:0] mem_rdata_i;

  logic             wb_en_o;
  logic [4:0]       wb_rd_o;
  logic [Width-1:0] wb_data_o;

  logic             misalign_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output wb_en_o, wb_rd_o, wb_data_o, misalign_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  wb_en_o, wb_rd_o, wb_data_o, misalign_o, busy_o
  );
endinterface

// File: rtl/lsu_wb_ctrl.sv
// Multi-cycle load/store unit: load accept->write-back in 3 cycles, store accept->idle in 2.
// Accepts one request at a time (ready only in IDLE); memory request held until granted.
module lsu_wb_ctrl #(
  parameter int Width = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  lsu_wb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [Width-1:0] addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;
  logic [Width-1:0] result_q, result_d;
  logic             misalign_q, misalign_d;

  logic             req_misaligned;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign req_misaligned = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0])
                        || ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00))
                        ||  (bus.req_size_i == 2'b11);

  assign rd_byte = bus.mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = bus.mem_rdata_i[{addr_q[1], 4'b0000} +: 16];

  // Memory-side fields come straight from the latched request so they stay stable while stalled.
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = {addr_q[Width-1:2], 2'b00};
  assign bus.misalign_o = misalign_q;
  assign bus.busy_o     = (state_q != IDLE);

  always_comb begin
    bus.mem_be_o    = 4'b1111;
    bus.mem_wdata_o = wdata_q;
    case (size_q)
      2'b00: begin
        bus.mem_be_o    = 4'b0001 << addr_q[1:0];
        bus.mem_wdata_o = {(Width/8){wdata_q[7:0]}};
      end
      2'b01: begin
        bus.mem_be_o    = 4'b0011 << addr_q[1:0];
        bus.mem_wdata_o = {(Width/16){wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    size_d          = size_q;
    uns_d           = uns_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rd_d            = rd_q;
    result_d        = result_q;
    misalign_d      = 1'b0;
    bus.req_ready_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.wb_en_o     = 1'b0;
    bus.wb_rd_o     = '0;
    bus.wb_data_o   = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          if (req_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            we_d    = bus.req_we_i;
            size_d  = bus.req_size_i;
            uns_d   = bus.req_unsigned_i;
            addr_d  = bus.req_addr_i;
            wdata_d = bus.req_wdata_i;
            rd_d    = bus.req_rd_i;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_gnt_i) begin
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          case (size_q)
            2'b00:   result_d = {{(Width-8){~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   result_d = {{(Width-16){~uns_q & rd_half[15]}}, rd_half};
            default: result_d = bus.mem_rdata_i;
          endcase
          state_d = WB;
        end
      end
      WB: begin
        // x0 is hardwired zero: the cycle still happens, only the write is masked.
        bus.wb_en_o   = (rd_q != 5'd0);
        bus.wb_rd_o   = rd_q;
        bus.wb_data_o = result_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 5'd0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: doc/lsu_wb_ctrl.md
LSU_WB_CTRL -- requirements
Module: lsu_wb_ctrl

Multi-cycle load/store unit. Issues data-memory transactions and drives the register-file write port (write enable, destination, write data) for loads.

Interface
REQ-001 The block SHALL have parameter Width, default 32, setting the data and address width.
REQ-002 The block SHALL use one clock, clk_i, with all state updated on its rising edge.
REQ-003 The block SHALL use reset rst_i, input, 1 bit, synchronous and active-high.
REQ-004 The block SHALL have req_valid_i, input, 1 bit: core access request valid.
REQ-005 The block SHALL have req_ready_o, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have req_we_i, input, 1 bit: 1 means store, 0 means load.
REQ-007 The block SHALL have req_size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The block SHALL have req_unsigned_i, input, 1 bit: zero-extend the load result (LBU/LHU).
REQ-009 The block SHALL have req_addr_i, input, Width bits: byte address.
REQ-010 The block SHALL have req_wdata_i, input, Width bits: store data, right-aligned.
REQ-011 The block SHALL have req_rd_i, input, 5 bits: load destination register.
REQ-012 The block SHALL have mem_req_o, mem_we_o (outputs, 1 bit each), mem_addr_o (output, Width bits, word-aligned), mem_be_o (output, 4 bits) and mem_wdata_o (output, Width bits).
REQ-013 The block SHALL have mem_gnt_i, mem_rvalid_i (inputs, 1 bit each) and mem_rdata_i (input, Width bits).
REQ-014 The block SHALL have wb_en_o (output, 1 bit), wb_rd_o (output, 5 bits) and wb_data_o (output, Width bits), forming the register-file write port.
REQ-015 The block SHALL have misalign_o, output, 1 bit: misaligned/illegal access pulse.
REQ-016 The block SHALL have busy_o, output, 1 bit: block not in IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, WAIT and WB; busy_o SHALL be 1 in every state except IDLE.
REQ-018 In IDLE the block SHALL drive req_ready_o=1, and a request SHALL be accepted on req_valid_i & req_ready_o; in all other states req_ready_o SHALL be 0.
REQ-019 An accepted request SHALL be misaligned when any of these holds: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11.
REQ-020 A misaligned request SHALL make misalign_o 1 for exactly the next cycle, SHALL cause no memory access and no write-back, and SHALL leave the FSM in IDLE.
REQ-021 An aligned request SHALL be latched (we, size, unsigned, addr, wdata, rd), and the FSM SHALL move to REQ.
REQ-022 In REQ, mem_req_o SHALL be 1 and mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o SHALL be held stable until the cycle in which mem_gnt_i=1 is sampled.
REQ-023 mem_addr_o SHALL equal {addr[Width-1:2],2'b00}.
REQ-024 mem_be_o SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word.
REQ-025 mem_wdata_o SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-026 A store SHALL move REQ->IDLE on grant and SHALL produce no write-back.
REQ-027 A load SHALL move REQ->WAIT on grant.
REQ-028 In WAIT the block SHALL sample mem_rvalid_i only (an rvalid coincident with the grant cycle SHALL be ignored); on rvalid=1 it SHALL capture the result and move to WB.
REQ-029 The load result for a byte access SHALL be lane rdata>>(8*addr[1:0]), bits [7:0], sign-extended from bit 7, or zero-extended when unsigned.
REQ-030 The load result for a half access SHALL be rdata>>(16*addr[1]), bits [15:0], sign-extended from bit 15, or zero-extended when unsigned.
REQ-031 The load result for a word access SHALL be rdata unchanged, with req_unsigned_i ignored.
REQ-032 In WB, wb_en_o SHALL be 1 for exactly one cycle with wb_rd_o/wb_data_o valid, and the FSM SHALL then move to IDLE.
REQ-033 When rd=0, wb_en_o SHALL be 0 in WB; the state sequence SHALL otherwise be unchanged.
REQ-034 Outside WB, wb_en_o SHALL be 0, and wb_rd_o/wb_data_o SHALL be 0.
REQ-035 Outside REQ, mem_req_o SHALL be 0.
REQ-036 Minimum load latency SHALL be: accept at cycle T, mem_req_o at T+1, grant at T+1, rvalid at T+2, wb_en_o at T+3. A new request SHALL be acceptable at T+4.
REQ-037 Minimum store latency SHALL be: accept at cycle T, mem_req_o at T+1, grant at T+1, IDLE at T+2.

Reset
REQ-038 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and all latched fields SHALL clear to 0.
REQ-039 The cycle after reset SHALL have req_ready_o=1 and mem_req_o, wb_en_o, misalign_o and busy_o all 0.
REQ-040 A reset mid-transaction (REQ/WAIT/WB) SHALL abandon the transaction, SHALL suppress its write-back, and SHALL cause any later rvalid to be ignored in IDLE.

Verification
REQ-041 The bench SHALL check: LB at addr 0x103, rd=5, rdata=0x80FFFFFF -> be=1000, wb_en_o=1, wb_rd_o=5, wb_data_o=0xFFFFFF80; the same access as LBU -> wb_data_o=0x00000080.
REQ-042 The bench SHALL check: LH at addr 0x202, rdata=0x8001_1234, unsigned=0 -> be=1100, wb_data_o=0xFFFF8001.
REQ-043 The bench SHALL check: SB at addr 0x11, wdata=0x000000AB -> mem_addr_o=0x10, be=0010, mem_wdata_o=0xABABABAB, mem_we_o=1, no wb_en_o.
REQ-044 The bench SHALL check: LW at addr 0x6, or size=11 -> misalign_o=1 for one cycle, mem_req_o stays 0, FSM stays in IDLE.
REQ-045 The bench SHALL check: mem_gnt_i held 0 for 3 cycles -> mem_req_o and address/be/wdata stable across all 3 cycles, req_ready_o=0 throughout.
REQ-046 The bench SHALL check: LW with rd=0 -> full handshake, wb_en_o=0; rst_i asserted in WAIT -> IDLE next cycle and a subsequent rvalid produces no write-back.
